// File: rtl/counter_sweep_pkg.sv
`default_nettype none
// ============================================================================
// counter_sweep_pkg
//   Shared state type and width defaults for the counter sweep controller.
//   Rev 1.0
// ============================================================================
package counter_sweep_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int SW_W_DEF  = 4;
  localparam int TMR_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEEK      = 3'd1,
    ST_RAMP_UP   = 3'd2,
    ST_DWELL_HI  = 3'd3,
    ST_RAMP_DOWN = 3'd4,
    ST_DWELL_LO  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sweep_dwell_timer.sv
`default_nettype none
// ============================================================================
// sweep_dwell_timer
//   Loadable down counter with zero flag; used for turnaround dwell waits.
//   Rev 1.0
// ============================================================================
module sweep_dwell_timer
  import counter_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             dec,
  output logic [TMR_W-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec) begin
      value <= value - TMR_W'(1);
    end
  end

  assign zero = (value == '0);

endmodule
`default_nettype wire

// File: rtl/counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// counter_sweep_ctrl
//   Drives an up/down counter through repeated lo->hi->lo triangle sweeps.
//   Rev 1.0
// ============================================================================
module counter_sweep_ctrl
  import counter_sweep_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DWELL = 4,
  parameter int SW_W  = SW_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [SW_W-1:0]  sweeps,
  input  logic [WIDTH-1:0] counter_in,
  output logic             enable,
  output logic             direction,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SW_W-1:0]  sweep_cnt
);

  localparam logic [TMR_W-1:0] c_dwell_load = TMR_W'(DWELL - 1);

  state_t            r_state;
  logic [WIDTH-1:0]  r_lo;
  logic [WIDTH-1:0]  r_hi;
  logic [SW_W-1:0]   r_sweeps;
  logic [SW_W-1:0]   w_cnt_inc;
  logic              w_at_lo;
  logic              w_at_hi;
  logic              w_in_dwell;
  logic              w_tmr_load;
  logic              w_tmr_dec;
  logic              w_tmr_zero;
  logic [TMR_W-1:0]  w_tmr_value;

  assign w_at_lo    = (counter_in == r_lo);
  assign w_at_hi    = (counter_in == r_hi);
  assign w_cnt_inc  = sweep_cnt + SW_W'(1);
  assign w_in_dwell = (r_state == ST_DWELL_HI) || (r_state == ST_DWELL_LO);
  // Loading on every limit arrival is harmless on the final one: IDLE ignores the timer.
  assign w_tmr_load = !abort && (((r_state == ST_RAMP_UP) && w_at_hi) ||
                                 ((r_state == ST_RAMP_DOWN) && w_at_lo));
  assign w_tmr_dec  = w_in_dwell && (w_tmr_value != '0);

  sweep_dwell_timer u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_tmr_load),
    .load_val (c_dwell_load),
    .dec      (w_tmr_dec),
    .value    (w_tmr_value),
    .zero     (w_tmr_zero)
  );

  // Counter commands are combinational so the counter halts exactly on a limit.
  always_comb begin
    enable    = 1'b0;
    direction = 1'b1;
    case (r_state)
      ST_SEEK: begin
        direction = (counter_in < r_lo);
        enable    = !w_at_lo;
      end
      ST_RAMP_UP: begin
        enable = !w_at_hi;
      end
      ST_RAMP_DOWN: begin
        direction = 1'b0;
        enable    = !w_at_lo;
      end
      ST_DWELL_LO: begin
        direction = 1'b0;
      end
      default: begin
        enable    = 1'b0;
        direction = 1'b1;
      end
    endcase
    if (rst || abort) begin
      enable = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_lo      <= '0;
      r_hi      <= '0;
      r_sweeps  <= '0;
      sweep_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              if ((hi > lo) && (sweeps != '0)) begin
                r_lo      <= lo;
                r_hi      <= hi;
                r_sweeps  <= sweeps;
                sweep_cnt <= '0;
                busy      <= 1'b1;
                r_state   <= ST_SEEK;
              end else begin
                err <= 1'b1;
              end
            end
          end
          ST_SEEK: begin
            if (w_at_lo) r_state <= ST_RAMP_UP;
          end
          ST_RAMP_UP: begin
            if (w_at_hi) r_state <= ST_DWELL_HI;
          end
          ST_DWELL_HI: begin
            if (w_tmr_zero) r_state <= ST_RAMP_DOWN;
          end
          ST_RAMP_DOWN: begin
            if (w_at_lo) begin
              sweep_cnt <= w_cnt_inc;
              if (w_cnt_inc == r_sweeps) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_DWELL_LO;
              end
            end
          end
          ST_DWELL_LO: begin
            if (w_tmr_zero) r_state <= ST_RAMP_UP;
          end
          default: begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
